// File: rtl/if_id_skid_pkg.sv
// Shared definitions for the IF/ID skid stage: FSM encodings, bubble instruction, counter width.
// The optional fetch-stall counter is built when IF_ID_STALL_CNT_EN is defined.
package if_id_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } if_id_state_e;

  localparam logic [15:0] IF_ID_NOP   = 16'h0800;
  localparam int          STALL_CNT_W = 16;

endpackage

// File: rtl/if_id_skid_entry.sv
// One {instr, pc2} holding entry; a plain enable register with no reset, since
// the stage's state decides whether its contents are ever visible.
module if_id_entry #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (en_i) data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID stage with a main entry and one skid entry; ready/valid come from state only.
// Optional fetch-stall counter on stall_cnt when IF_ID_STALL_CNT_EN is defined.
module if_id_skid_stage
  import if_id_skid_pkg::*;
#(
  parameter int                 DATA_W    = 16,
  parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(IF_ID_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_pc2
`ifdef IF_ID_STALL_CNT_EN
  , output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int EW = 2 * DATA_W;

  if_id_state_e  state_q;
  logic          in_fire, out_fire, upd;
  logic          main_en, skid_en;
  logic [EW-1:0] main_d, main_q, skid_q, in_ent;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign upd       = rst & ~flush;
  assign in_ent    = {in_instr, in_pc2};

  // Main refills from the skid when draining FULL, otherwise from fetch.
  always_comb begin
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_ent;
    unique case (state_q)
      ST_EMPTY: main_en = upd & in_fire;
      ST_BUSY: begin
        main_en = upd & in_fire & out_fire;
        skid_en = upd & in_fire & ~out_fire;
      end
      ST_FULL: begin
        main_en = upd & out_fire;
        main_d  = skid_q;
      end
      default: ;
    endcase
  end

  if_id_entry #(.W(EW)) u_main (
    .clk  (clk),
    .en_i (main_en),
    .d_i  (main_d),
    .q_o  (main_q)
  );

  if_id_entry #(.W(EW)) u_skid (
    .clk  (clk),
    .en_i (skid_en),
    .d_i  (in_ent),
    .q_o  (skid_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (in_fire) state_q <= ST_BUSY;
        ST_BUSY: begin
          if (in_fire && !out_fire)      state_q <= ST_FULL;
          else if (!in_fire && out_fire) state_q <= ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_q <= ST_BUSY;
        default:  state_q <= ST_EMPTY;
      endcase
    end
  end

  assign out_instr = out_valid ? main_q[EW-1:DATA_W] : NOP_INSTR;
  assign out_pc2   = out_valid ? main_q[DATA_W-1:0]  : '0;

`ifdef IF_ID_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Flush deliberately leaves the count alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt_q <= '0;
    else if (in_valid && !in_ready && stall_cnt_q != {STALL_CNT_W{1'b1}})
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: directed scenarios then random traffic, all checked
// against a FIFO-of-two reference model; stall_cnt checked when the macro is on.
module tb_if_id_skid_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] in_instr, in_pc2, out_instr, out_pc2;
`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  if_id_skid_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc2    (in_pc2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc2   (out_pc2)
`ifdef IF_ID_STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the stage is an in-order queue holding at most two instructions.
  logic [31:0] mq[$];
  int unsigned m_cnt = 0;
  logic        m_fired;

  function automatic logic m_ready();
    return mq.size() < 2;
  endfunction

  task automatic model_edge();
    logic ifire, ofire;
    ifire   = in_valid && m_ready();
    ofire   = (mq.size() > 0) && out_ready;
    m_fired = rst && !flush && ifire;
    if (!rst) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      if (in_valid && !m_ready() && m_cnt < 16'hFFFF) m_cnt++;
      if (ofire) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (ifire) mq.push_back({in_instr, in_pc2});
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("in_ready",  32'(in_ready),  32'(m_ready()));
    chk("out_instr", 32'(out_instr), (mq.size() > 0) ? 32'(mq[0][31:16]) : 32'h0800);
    chk("out_pc2",   32'(out_pc2),   (mq.size() > 0) ? 32'(mq[0][15:0])  : 32'h0);
`ifdef IF_ID_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [15:0] ins, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_instr = ins; in_pc2 = ins + 16'h0002;
    out_ready = ordy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic        hold;
    logic [15:0] hins;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc2 = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset held two cycles with fetch presenting an instruction.
    step(0, 0, 1, 16'h1234, 1);
    step(0, 0, 1, 16'h1234, 1);
    chk("rst_nop", 32'(out_instr), 32'h0800);
    chk("rst_rdy", 32'(in_ready), 32'h1);

    // Streaming at full rate.
    step(1, 0, 1, 16'hA000, 1);
    chk("stream_lat", 32'(out_instr), 32'hA000);
    step(1, 0, 1, 16'hA002, 1);
    step(1, 0, 1, 16'hA004, 1);
    chk("stream_in", 32'(out_instr), 32'hA004);
    step(1, 0, 0, 16'h0, 1);

    // Back-pressure into FULL, then drain with B104 waiting at the input.
    step(1, 0, 1, 16'hB100, 0);
    step(1, 0, 1, 16'hB102, 0);
    chk("bp_full", 32'(in_ready), 32'h0);
    step(1, 0, 1, 16'hB104, 0);
    step(1, 0, 1, 16'hB104, 0);
    step(1, 0, 1, 16'hB104, 1);
    chk("bp_b102", 32'(out_instr), 32'hB102);
    step(1, 0, 1, 16'hB104, 1);
    chk("bp_b104", 32'(out_instr), 32'hB104);
    step(1, 0, 0, 16'h0, 1);

    // Flush while FULL with a new instruction offered.
    step(1, 0, 1, 16'hC000, 0);
    step(1, 0, 1, 16'hC002, 0);
    step(1, 1, 1, 16'hC004, 0);
    chk("flush_vld", 32'(out_valid), 32'h0);
    chk("flush_nop", 32'(out_instr), 32'h0800);
    step(1, 0, 0, 16'h0, 1);

    // BUSY with simultaneous accept and consume.
    step(1, 0, 1, 16'hD000, 0);
    step(1, 0, 1, 16'hD002, 1);
    chk("busy_swap", 32'(out_instr), 32'hD002);
    chk("busy_rdy",  32'(in_ready), 32'h1);
    step(1, 0, 0, 16'h0, 1);

    // Reset while FULL.
    step(1, 0, 1, 16'hE000, 0);
    step(1, 0, 1, 16'hE002, 0);
    step(1, 0, 1, 16'hE004, 0);
    step(0, 0, 1, 16'hE004, 0);
    chk("rst_full", 32'(out_valid), 32'h0);

    // Random traffic; the source holds an offered instruction until it is taken.
    hold = 1'b0; hins = '0;
    for (int i = 0; i < 3000; i++) begin
      logic r, f, iv, ordy;
      logic [15:0] ins;
      r    = ($urandom_range(0, 199) != 0);
      f    = ($urandom_range(0, 24) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      if (hold) begin
        iv = 1'b1; ins = hins;
      end else begin
        iv = $urandom_range(0, 3) != 0; ins = 16'($urandom);
      end
      step(r, f, iv, ins, ordy);
      hold = iv && !m_fired && r && !f;
      hins = ins;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
